input_fetcher: RTL
==================

INPUT_FETCHER -- requirements
Module: input_fetcher

Interface
REQ-001 Parameter IMG_H, default 58: image height in pixels, padding included.
REQ-002 Parameter IMG_W, default 58: image width in pixels, padding included.
REQ-003 clk  input  1  clock; all logic samples on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle frame-start pulse; sampled only in IDLE.
REQ-006 sram_rd_en  output  1  input-SRAM read enable.
REQ-007 sram_rd_addr  output  14  input-SRAM read address, row-major (r*IMG_W+c).
REQ-008 sram_rd_data  input  9  SRAM read data; valid the cycle after the address is presented.
REQ-009 pix  output  9  registered pixel stream to the 3x3 line buffer (Y input).
REQ-010 pix_vld  output  1  pix carries a valid pixel this cycle.
REQ-011 win_vld  output  1  line-buffer R0..R8 hold a complete, in-row 3x3 window this cycle.
REQ-012 win_row  output  6  top-left row of the valid window.
REQ-013 win_col  output  6  top-left column of the valid window.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse at frame end.

Function
REQ-016 FSM states: IDLE, READ, DRAIN, DONE; state register is binary-encoded.
REQ-017 IDLE->READ on start=1; start in any other state is ignored.
REQ-018 READ: sram_rd_en=1; sram_rd_addr steps 0,1,...,IMG_H*IMG_W-1, one address per cycle, registered.
REQ-019 A row counter r and a column counter c track each issued address; c wraps IMG_W-1->0 and increments r at the wrap.
REQ-020 READ->DRAIN in the cycle after the last address (IMG_H*IMG_W-1) is issued; sram_rd_en=0 and sram_rd_addr holds its last value in DRAIN.
REQ-021 Pixel stage: for an address issued in cycle n, pix=sram_rd_data and pix_vld=1 in cycle n+2; otherwise pix_vld=0 and pix holds its last value.
REQ-022 Window stage: for an address (r,c) issued in cycle n with r>=2 and c>=2, win_vld=1 in cycle n+3 with win_row=r-2 and win_col=c-2; otherwise win_vld=0.
REQ-023 The pipeline delays (r,c) and the valid flag alongside the data; the design does not recompute them from the address.
REQ-024 No win_vld at c=0 or c=1 of any row: these windows straddle a row boundary.
REQ-025 DRAIN lasts 3 cycles, until the last window is out; DRAIN->DONE.
REQ-026 DONE: done=1 for exactly one cycle, then DONE->IDLE; busy=0 from that IDLE cycle on.
REQ-027 Frame totals: IMG_H*IMG_W read cycles and (IMG_H-2)*(IMG_W-2) win_vld pulses; defaults give 3364 and 3136.
REQ-028 Back-to-back frames: a start in the first IDLE cycle after DONE begins a new frame from address 0.

Reset
REQ-029 rst=1 forces IDLE immediately, regardless of clk.
REQ-030 Reset values: sram_rd_en, sram_rd_addr, pix, pix_vld, win_vld, win_row, win_col, busy and done all 0; all counters and pipeline flags 0.
REQ-031 Reset mid-frame discards all in-flight pixels; no win_vld or done follows until a new start.

Configuration
REQ-032 Macro FETCH_STALL_EN, when defined, adds input stall (1 bit).
REQ-033 With FETCH_STALL_EN, stall=1 in READ freezes the address and counters, drives sram_rd_en=0, and inserts a bubble (pix_vld=0, win_vld=0) at the same pipeline positions; issue resumes at the held address.
REQ-034 Without FETCH_STALL_EN the stall port does not exist and READ never pauses.

Verification
REQ-035 Assert rst asynchronously mid-cycle -> all outputs read 0 immediately and the state is IDLE.
REQ-036 Full frame with SRAM model data=addr[8:0] -> 3364 consecutive sram_rd_en cycles; pix sequence equals addr[8:0] with a 2-cycle lag; 3136 win_vld pulses; first pulse 3 cycles after addr 118 with win_row=0, win_col=0; last pulse 3 cycles after addr 3363 with win_row=55, win_col=55; done in the cycle after the last pulse.
REQ-037 Row boundary -> no win_vld attributable to addr 174 or 175 (r=3, c=0/1); addr 176 -> win_vld with win_row=1, win_col=0.
REQ-038 Extra start pulse at addr 500 -> no effect: addresses continue 501, 502, ... and frame totals are unchanged.
REQ-039 rst pulse when addr=1000 -> outputs 0 and no done; a following start restarts at addr 0 and completes a full frame.
REQ-040 FETCH_STALL_EN defined, stall high 5 cycles at addr 200 -> addr holds at 200, 5-cycle bubble in pix_vld, totals still 3364/3136, done delayed by 5 cycles.

Source files
------------

// File: rtl/input_fetcher.sv
// Input fetcher: streams a padded image from the input SRAM in row-major order and
// tags each pixel with its 3x3 window position. Optional stall input via FETCH_STALL_EN.
//
// state | meaning
// IDLE  | waiting for start
// READ  | issuing one SRAM address per cycle
// DRAIN | 3 cycles letting the last pixel reach the window stage
// DONE  | one-cycle frame-end pulse
module input_fetcher #(
  parameter int IMG_H = 58,
  parameter int IMG_W = 58
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
`ifdef FETCH_STALL_EN
  input  logic        stall,
`endif
  output logic        sram_rd_en,
  output logic [13:0] sram_rd_addr,
  input  logic [8:0]  sram_rd_data,
  output logic [8:0]  pix,
  output logic        pix_vld,
  output logic        win_vld,
  output logic [5:0]  win_row,
  output logic [5:0]  win_col,
  output logic        busy,
  output logic        done
);

  localparam logic [13:0] LAST_ADDR = 14'(IMG_H * IMG_W - 1);
  localparam logic [5:0]  LAST_COL  = 6'(IMG_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic        issue;
  logic        last_issue;
  logic [5:0]  row, col;
  logic [1:0]  drain_cnt;
  logic        vld1, vld2;
  logic [5:0]  row1, col1, row2, col2;

`ifdef FETCH_STALL_EN
  assign issue = (state == READ) && !stall;
`else
  assign issue = (state == READ);
`endif
  assign last_issue = issue && (sram_rd_addr == LAST_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    sram_rd_en = issue;
    busy       = (state != IDLE);
    done       = (state == DONE);
    case (state)
      IDLE:    if (start) state_nxt = READ;
      READ:    if (last_issue) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == 2'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address and (row, col) counters advance together; they hold on stall and after the last issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_rd_addr <= '0;
      row          <= '0;
      col          <= '0;
    end else if (state == IDLE && start) begin
      sram_rd_addr <= '0;
      row          <= '0;
      col          <= '0;
    end else if (issue && !last_issue) begin
      sram_rd_addr <= sram_rd_addr + 14'd1;
      if (col == LAST_COL) begin
        col <= '0;
        row <= row + 6'd1;
      end else begin
        col <= col + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   drain_cnt <= '0;
    else if (last_issue)                       drain_cnt <= 2'd2;
    else if (state == DRAIN && drain_cnt != 0) drain_cnt <= drain_cnt - 2'd1;
  end

  // Position and valid travel with the data so stalls become bubbles automatically.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld1    <= 1'b0;
      row1    <= '0;
      col1    <= '0;
      pix_vld <= 1'b0;
      pix     <= '0;
      vld2    <= 1'b0;
      row2    <= '0;
      col2    <= '0;
      win_vld <= 1'b0;
      win_row <= '0;
      win_col <= '0;
    end else begin
      vld1    <= issue;
      row1    <= row;
      col1    <= col;
      pix_vld <= vld1;
      if (vld1) pix <= sram_rd_data;
      vld2    <= vld1;
      row2    <= row1;
      col2    <= col1;
      win_vld <= vld2 && (row2 >= 6'd2) && (col2 >= 6'd2);
      if (vld2 && (row2 >= 6'd2) && (col2 >= 6'd2)) begin
        win_row <= row2 - 6'd2;
        win_col <= col2 - 6'd2;
      end
    end
  end

endmodule
